// File: rtl/cube_sum_accum.sv
// cube_sum_accum: collects N_SAMPLES cube results from the sequential x^3 unit
// into a saturating running sum. The sum is held on a valid/ready output until
// it is accepted. Samples that arrive while a finished sum is waiting are
// dropped and reported with a one-cycle pulse.
module cube_sum_accum #(
    parameter int N_SAMPLES = 4,
    parameter int IN_W      = 6,
    parameter int SUM_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  cube_in,
    input  logic             cube_vld,
    input  logic             sum_rdy,
    output logic [SUM_W-1:0] sum_out,
    output logic             sum_vld,
    output logic             busy,
    output logic             ovf,
    output logic             drop
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] count;

    logic [SUM_W:0]   add_full;
    logic             carry;
    logic [SUM_W-1:0] acc_add;
    logic [SUM_W-1:0] first_val;
    logic             handshake;
    logic             start_batch;

    // Saturating add and batch-start decode. A sample that arrives in the same
    // cycle as the handshake opens the next batch instead of being dropped.
    always_comb begin
        first_val   = SUM_W'(cube_in);
        add_full    = {1'b0, acc} + (SUM_W + 1)'(cube_in);
        carry       = add_full[SUM_W];
        acc_add     = carry ? '1 : add_full[SUM_W-1:0];
        handshake   = sum_vld && sum_rdy;
        start_batch = cube_vld && ((state == IDLE) || (state == HOLD && handshake));
    end

    // Batch FSM with accumulator, counter and all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            sum_out <= '0;
            sum_vld <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            drop    <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (start_batch) begin
                acc   <= first_val;
                count <= CNT_W'(1);
                ovf   <= 1'b0;
                busy  <= 1'b1;
                if (N_SAMPLES == 1) begin
                    state   <= HOLD;
                    sum_vld <= 1'b1;
                    sum_out <= first_val;
                end else begin
                    state   <= ACCUM;
                    sum_vld <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        sum_vld <= 1'b0;
                        busy    <= 1'b0;
                    end
                    ACCUM: begin
                        if (cube_vld) begin
                            acc   <= acc_add;
                            count <= count + 1'b1;
                            ovf   <= ovf | carry;
                            if (count == LAST_IDX) begin
                                state   <= HOLD;
                                sum_vld <= 1'b1;
                                sum_out <= acc_add;
                            end
                        end
                    end
                    HOLD: begin
                        if (handshake) begin
                            state   <= IDLE;
                            sum_vld <= 1'b0;
                            busy    <= 1'b0;
                        end else if (cube_vld) begin
                            drop <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        sum_vld <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cube_sum_accum.sv
// Bench for cube_sum_accum: two instances (8-bit and 6-bit sum) share one
// stimulus stream and are compared every cycle against a batch-level model.
module tb_cube_sum_accum;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] cube_in;
    logic       cube_vld;
    logic       sum_rdy;

    logic [7:0] s8;
    logic       v8, b8, o8, d8;
    logic [5:0] s6;
    logic       v6, b6, o6, d6;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    // Reference model: samples of the batch being collected or held.
    int unsigned q[$];
    int unsigned exp_sum8, exp_sum6;
    bit          exp_ovf8, exp_ovf6, exp_drop;

    cube_sum_accum #(.N_SAMPLES(N), .IN_W(6), .SUM_W(8)) dut8 (
        .clk(clk), .rst(rst), .cube_in(cube_in), .cube_vld(cube_vld),
        .sum_rdy(sum_rdy), .sum_out(s8), .sum_vld(v8), .busy(b8),
        .ovf(o8), .drop(d8)
    );

    cube_sum_accum #(.N_SAMPLES(N), .IN_W(6), .SUM_W(6)) dut6 (
        .clk(clk), .rst(rst), .cube_in(cube_in), .cube_vld(cube_vld),
        .sum_rdy(sum_rdy), .sum_out(s6), .sum_vld(v6), .busy(b6),
        .ovf(o6), .drop(d6)
    );

    always #5 clk = ~clk;

    function automatic int unsigned batch_total();
        int unsigned t = 0;
        foreach (q[i]) t += q[i];
        return t;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_sum8 = 0;
        exp_sum6 = 0;
        exp_ovf8 = 1'b0;
        exp_ovf6 = 1'b0;
        exp_drop = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs sampled at it.
    task automatic model_edge();
        int unsigned t;
        exp_drop = 1'b0;
        if (q.size() == N) begin
            if (sum_rdy) begin
                q.delete();
                if (cube_vld) q.push_back(int'(cube_in));
            end else if (cube_vld) begin
                exp_drop = 1'b1;
            end
        end else if (cube_vld) begin
            q.push_back(int'(cube_in));
        end
        t = batch_total();
        if (q.size() > 0) begin
            exp_ovf8 = (t > 255);
            exp_ovf6 = (t > 63);
        end
        if (q.size() == N) begin
            exp_sum8 = (t > 255) ? 255 : t;
            exp_sum6 = (t > 63) ? 63 : t;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        logic full, nonempty;
        full     = (q.size() == N);
        nonempty = (q.size() != 0);
        check({ph, ".vld8"},  32'(v8), 32'(full));
        check({ph, ".busy8"}, 32'(b8), 32'(nonempty));
        check({ph, ".drop8"}, 32'(d8), 32'(exp_drop));
        check({ph, ".ovf8"},  32'(o8), 32'(exp_ovf8));
        check({ph, ".sum8"},  32'(s8), exp_sum8);
        check({ph, ".vld6"},  32'(v6), 32'(full));
        check({ph, ".busy6"}, 32'(b6), 32'(nonempty));
        check({ph, ".drop6"}, 32'(d6), 32'(exp_drop));
        check({ph, ".ovf6"},  32'(o6), 32'(exp_ovf6));
        check({ph, ".sum6"},  32'(s6), exp_sum6);
    endtask

    task automatic cycle(input string ph, input logic vld, input logic [5:0] data, input logic rdy);
        cube_vld = vld;
        cube_in  = data;
        sum_rdy  = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    initial begin
        rst      = 1'b1;
        cube_vld = 1'b0;
        cube_in  = '0;
        sum_rdy  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 1: basic batch, immediate accept
        cycle("t1", 1'b1, 6'd8, 1'b1);
        cycle("t1", 1'b1, 6'd27, 1'b1);
        cycle("t1", 1'b1, 6'd1, 1'b1);
        cycle("t1", 1'b1, 6'd0, 1'b1);
        check("t1.sum36", 32'(s8), 32'd36);
        check("t1.vld_hi", 32'(v8), 32'd1);
        cycle("t1", 1'b0, 6'd0, 1'b1);
        check("t1.vld_lo", 32'(v8), 32'd0);

        // 2: backpressure and drop while held
        cycle("t2", 1'b1, 6'd8, 1'b0);
        cycle("t2", 1'b1, 6'd27, 1'b0);
        cycle("t2", 1'b1, 6'd1, 1'b0);
        cycle("t2", 1'b1, 6'd0, 1'b0);
        cycle("t2", 1'b0, 6'd0, 1'b0);
        cycle("t2", 1'b0, 6'd0, 1'b0);
        cycle("t2", 1'b1, 6'd8, 1'b0);
        check("t2.drop", 32'(d8), 32'd1);
        cycle("t2", 1'b0, 6'd0, 1'b0);
        check("t2.drop_end", 32'(d8), 32'd0);
        cycle("t2", 1'b0, 6'd0, 1'b0);
        check("t2.sum_held", 32'(s8), 32'd36);
        cycle("t2", 1'b0, 6'd0, 1'b1);
        cycle("t2", 1'b0, 6'd0, 1'b1);

        // 3: overflow on the 6-bit instance, cleared by the next batch
        cycle("t3", 1'b1, 6'd27, 1'b1);
        cycle("t3", 1'b1, 6'd27, 1'b1);
        cycle("t3", 1'b1, 6'd27, 1'b1);
        cycle("t3", 1'b1, 6'd1, 1'b1);
        check("t3.sat", 32'(s6), 32'd63);
        check("t3.ovf", 32'(o6), 32'd1);
        cycle("t3", 1'b0, 6'd0, 1'b1);
        check("t3.ovf_sticky", 32'(o6), 32'd1);
        for (int i = 0; i < 4; i++) cycle("t3b", 1'b1, 6'd1, 1'b1);
        check("t3.sum4", 32'(s6), 32'd4);
        check("t3.ovf_clr", 32'(o6), 32'd0);
        cycle("t3b", 1'b0, 6'd0, 1'b1);

        // 4: handshake and strobe in the same cycle
        cycle("t4", 1'b1, 6'd8, 1'b0);
        cycle("t4", 1'b1, 6'd0, 1'b0);
        cycle("t4", 1'b1, 6'd0, 1'b0);
        cycle("t4", 1'b1, 6'd0, 1'b0);
        cycle("t4", 1'b1, 6'd27, 1'b1);
        check("t4.nodrop", 32'(d8), 32'd0);
        cycle("t4", 1'b1, 6'd8, 1'b1);
        cycle("t4", 1'b1, 6'd8, 1'b1);
        cycle("t4", 1'b1, 6'd8, 1'b0);
        check("t4.sum51", 32'(s8), 32'd51);
        cycle("t4", 1'b0, 6'd0, 1'b1);

        // 5: gapped strobes
        cycle("t5", 1'b1, 6'd8, 1'b1);
        cycle("t5", 1'b0, 6'd0, 1'b1);
        cycle("t5", 1'b0, 6'd0, 1'b1);
        check("t5.busy_gap", 32'(b8), 32'd1);
        cycle("t5", 1'b1, 6'd0, 1'b1);
        cycle("t5", 1'b0, 6'd0, 1'b1);
        cycle("t5", 1'b1, 6'd27, 1'b1);
        cycle("t5", 1'b0, 6'd0, 1'b1);
        cycle("t5", 1'b1, 6'd1, 1'b0);
        check("t5.sum36", 32'(s8), 32'd36);
        cycle("t5", 1'b0, 6'd0, 1'b0);
        cycle("t5", 1'b0, 6'd0, 1'b1);
        check("t5.busy_done", 32'(b8), 32'd0);

        // 6: asynchronous reset mid-batch
        cycle("t6", 1'b1, 6'd5, 1'b1);
        cycle("t6", 1'b1, 6'd6, 1'b1);
        cube_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async");
        @(posedge clk);
        #1 rst = 1'b0;
        check_all("t6_rel");
        for (int i = 0; i < 4; i++) cycle("t6b", 1'b1, 6'd1, 1'b1);
        check("t6.sum4", 32'(s8), 32'd4);
        cycle("t6b", 1'b0, 6'd0, 1'b1);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 2) != 0), 6'($urandom_range(0, 63)),
                  ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
